// File: rtl/ti_poly_pkg.sv
// Shared defaults and serializer state encoding for the polyphase
// half-rate to full-rate recombiner.
package ti_poly_pkg;

  localparam int unsigned BW_DEFAULT    = 6;
  localparam int unsigned DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_PH_B = 2'd2
  } ser_state_e;

  // A single-entry FIFO still needs a 1-bit pointer to stay well-formed.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ti_pair_fifo.sv
// Small FIFO of sample pairs; count is registered so a push is never
// visible to a pop issued in the same cycle.
module ti_pair_fifo
  import ti_poly_pkg::*;
#(
  parameter int unsigned  DW    = 2 * BW_DEFAULT,
  parameter int unsigned  DEPTH = DEPTH_DEFAULT,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned   PW   = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ti_polyphase_interp2.sv
// Recombines half-rate polyphase pairs into a full-rate stream: each
// buffered pair is emitted as IN2 then IN1, back to back when available.
module ti_polyphase_interp2
  import ti_poly_pkg::*;
#(
  parameter int unsigned BW    = BW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 ENABLE,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic signed [BW-1:0] IN1,
  input  logic signed [BW-1:0] IN2,
  input  logic                 CLR_UF,
  output logic signed [BW-1:0] OUT,
  output logic                 OUT_VALID,
  output logic                 UNDERFLOW
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ser_state_e            state_q;
  logic signed [BW-1:0]  out_q;
  logic signed [BW-1:0]  hold_q;
  logic                  out_valid_q;
  logic                  uf_q;

  logic [CW-1:0]         count;
  logic [2*BW-1:0]       push_data;
  logic [2*BW-1:0]       pop_data;
  logic signed [BW-1:0]  pop_in1;
  logic signed [BW-1:0]  pop_in2;
  logic                  push;
  logic                  pop;

  // Readiness uses only the registered count: a full FIFO refuses a pair
  // even when the serializer drains an entry in the same cycle.
  assign IN_READY  = ENABLE && (count < FULL);
  assign push      = IN_READY && IN_VALID;
  assign push_data = {IN1, IN2};
  assign pop_in1   = pop_data[2*BW-1:BW];
  assign pop_in2   = pop_data[BW-1:0];
  assign pop       = ENABLE && (count != '0) &&
                     ((state_q == ST_IDLE) || (state_q == ST_PH_B));

  ti_pair_fifo #(
    .DW    (2 * BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RES),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .count_o     (count)
  );

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      uf_q        <= 1'b0;
    end else if (ENABLE) begin
      // Clear first so a same-edge underflow set takes priority.
      if (CLR_UF) begin
        uf_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q     <= ST_PH_A;
            out_q       <= pop_in2;
            hold_q      <= pop_in1;
            out_valid_q <= 1'b1;
          end
        end
        ST_PH_A: begin
          state_q <= ST_PH_B;
          out_q   <= hold_q;
        end
        ST_PH_B: begin
          if (pop) begin
            state_q     <= ST_PH_A;
            out_q       <= pop_in2;
            hold_q      <= pop_in1;
            out_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            uf_q        <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign UNDERFLOW = uf_q;

endmodule
